// File: rtl/uart_tx_fifo_pkg.sv
// Purpose : shared types and helpers for the UART transmit FIFO controller.
// Latency : n/a (types, encodings and a pure threshold function only).
// Backpressure: n/a.
package uart_tx_fifo_pkg;

    // Serializer feed FSM: IDLE waits for data, LOAD pops one byte into the
    // read register, PRESENT holds it on tx_data until the handshake.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2
    } tx_state_e;

    // trig_lvl encodings for the low-water threshold interrupt.
    typedef enum logic [1:0] {
        TRIG_ZERO    = 2'd0,
        TRIG_TWO     = 2'd1,
        TRIG_QUARTER = 2'd2,
        TRIG_HALF    = 2'd3
    } trig_lvl_e;

    // Occupancy threshold selected by trig_lvl for a FIFO of 'depth' entries.
    function automatic int unsigned thr_of(input logic [1:0] lvl, input int unsigned depth);
        int unsigned thr;
        case (trig_lvl_e'(lvl))
            TRIG_ZERO:    thr = 0;
            TRIG_TWO:     thr = 2;
            TRIG_QUARTER: thr = depth / 4;
            default:      thr = depth / 2;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Purpose : DEPTH x DATA_W byte store, one write port, one registered read port.
// Latency : write lands at the clock edge; rd_data updates one edge after rd_en.
// Backpressure: none; the controller guarantees it never reads an unwritten slot.
// Ports   : clock/reset, wr_en/wr_addr/wr_data write port,
//           rd_en/rd_addr read request, rd_data registered read result.
module uart_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Storage array deliberately has no reset; only the read register does,
    // so the presented byte comes up as zero.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Purpose : UART TX FIFO: buffers host bytes, feeds the serializer, raises status.
// Latency : byte written at edge N is presented (tx_valid=1) from edge N+2 when idle and enabled.
// Backpressure: tx_data held until tx_valid&&tx_ready; writes while full are dropped and flag ovr_err.
// Ports   : clock/reset; wr_en/wr_data host write; fifo_clr flush; trig_lvl threshold select;
//           tx_enable launch gate; tx_valid/tx_data/tx_ready serializer handshake;
//           fifo_ptr occupancy, full, empty, thr_irq, ovr_err status.
module uart_tx_fifo_ctrl
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              fifo_clr,
    input  logic [1:0]        trig_lvl,
    input  logic              tx_enable,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic [PTR_W:0]    fifo_ptr,
    output logic              full,
    output logic              empty,
    output logic              thr_irq,
    output logic              ovr_err
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    tx_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [CNT_W-1:0]  thr_val;
    logic              wr_acc;
    logic              pop;
    logic              thr_q;
    logic              ovr_q;

    // Status flags derive from the count register itself, so they move on
    // exactly the same edge as fifo_ptr.
    assign fifo_ptr = count;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign thr_irq  = thr_q;
    assign ovr_err  = ovr_q;

    assign thr_val  = CNT_W'(thr_of(trig_lvl, DEPTH));

    // full is the start-of-cycle value: a concurrent pop does not make room.
    assign wr_acc   = wr_en && !full && !fifo_clr;

    // ---------------- FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && tx_enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pop     = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                // tx_enable only gates the next LOAD; a presented byte stays up.
                tx_valid = 1'b1;
                if (tx_ready) begin
                    state_d = (!empty && tx_enable) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over everything; a handshake in the same cycle simply
        // completes, the flush then discards whatever is still queued.
        if (fifo_clr) begin
            state_d = IDLE;
            pop     = 1'b0;
        end
    end

    // ---------------- pointers and count ----------------
    always_comb begin
        count_nxt = count;
        if (fifo_clr) begin
            count_nxt = '0;
        end else if (wr_acc && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!wr_acc && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            thr_q  <= 1'b1;
            ovr_q  <= 1'b0;
        end else begin
            count <= count_nxt;
            thr_q <= (count_nxt <= thr_val);
            if (fifo_clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovr_q  <= 1'b0;
            end else begin
                // Power-of-two depth: natural wrap of the pointer is modulo DEPTH.
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (wr_en && full) begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- storage ----------------
    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (tx_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Purpose : self-checking bench for uart_tx_fifo_ctrl (DEPTH=16, DATA_W=8).
// Latency : n/a.
// Backpressure: n/a.
module tb_uart_tx_fifo_ctrl;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;
    localparam int PTR_W  = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              fifo_clr;
    logic [1:0]        trig_lvl;
    logic              tx_enable;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic [PTR_W:0]    fifo_ptr;
    logic              full;
    logic              empty;
    logic              thr_irq;
    logic              ovr_err;

    int total = 0;
    int bad   = 0;

    // Bytes expected at the serializer, in order.
    logic [7:0] sb [$];

    typedef struct {
        logic       wr;
        logic [7:0] dat;
        logic       en;
        logic       rdy;
        logic [1:0] trig;
        logic       acc;
        logic [4:0] e_ptr;
        logic       e_emp;
        logic       e_full;
        logic       e_thr;
        logic       e_vld;
    } vec_t;

    uart_tx_fifo_ctrl #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .fifo_clr  (fifo_clr),
        .trig_lvl  (trig_lvl),
        .tx_enable (tx_enable),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .fifo_ptr  (fifo_ptr),
        .full      (full),
        .empty     (empty),
        .thr_irq   (thr_irq),
        .ovr_err   (ovr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int wr, input int dat, input int en, input int rdy,
                                input int trig, input int acc, input int ptr, input int emp,
                                input int ful, input int thr, input int vld);
        vec_t v;
        v.wr     = wr[0];
        v.dat    = dat[7:0];
        v.en     = en[0];
        v.rdy    = rdy[0];
        v.trig   = trig[1:0];
        v.acc    = acc[0];
        v.e_ptr  = ptr[4:0];
        v.e_emp  = emp[0];
        v.e_full = ful[0];
        v.e_thr  = thr[0];
        v.e_vld  = vld[0];
        return v;
    endfunction

    // Inputs change at posedge+1, so a handshake seen at the negedge will
    // complete at the following posedge.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(sb.size()), 32'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vld"},  32'(tx_valid), 32'(0));
        chk({tag, "_data"}, 32'(tx_data),  32'(0));
        chk({tag, "_ptr"},  32'(fifo_ptr), 32'(0));
        chk({tag, "_emp"},  32'(empty),    32'(1));
        chk({tag, "_full"}, 32'(full),     32'(0));
        chk({tag, "_thr"},  32'(thr_irq),  32'(1));
        chk({tag, "_ovr"},  32'(ovr_err),  32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [17];

        //          wr dat   en rdy trg acc  ptr emp ful thr vld
        vt[0]  = mk(1, 'hA5, 1, 1,  0,  1,   1,  0,  0,  0,  0);
        vt[1]  = mk(0, 0,    1, 1,  0,  0,   1,  0,  0,  0,  0);
        vt[2]  = mk(0, 0,    1, 1,  0,  0,   0,  1,  0,  1,  1);
        vt[3]  = mk(0, 0,    1, 1,  0,  0,   0,  1,  0,  1,  0);
        vt[4]  = mk(1, 'h31, 0, 1,  1,  1,   1,  0,  0,  1,  0);
        vt[5]  = mk(1, 'h32, 0, 1,  1,  1,   2,  0,  0,  1,  0);
        vt[6]  = mk(1, 'h33, 0, 1,  1,  1,   3,  0,  0,  0,  0);
        vt[7]  = mk(1, 'h34, 0, 1,  1,  1,   4,  0,  0,  0,  0);
        vt[8]  = mk(0, 0,    1, 1,  1,  0,   4,  0,  0,  0,  0);
        vt[9]  = mk(0, 0,    1, 1,  1,  0,   3,  0,  0,  0,  1);
        vt[10] = mk(0, 0,    1, 1,  1,  0,   3,  0,  0,  0,  0);
        vt[11] = mk(0, 0,    1, 1,  1,  0,   2,  0,  0,  1,  1);
        vt[12] = mk(0, 0,    1, 1,  1,  0,   2,  0,  0,  1,  0);
        vt[13] = mk(0, 0,    1, 1,  1,  0,   1,  0,  0,  1,  1);
        vt[14] = mk(0, 0,    1, 1,  1,  0,   1,  0,  0,  1,  0);
        vt[15] = mk(0, 0,    1, 1,  1,  0,   0,  1,  0,  1,  1);
        vt[16] = mk(0, 0,    1, 1,  1,  0,   0,  1,  0,  1,  0);

        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        fifo_clr  = 1'b0;
        trig_lvl  = 2'd0;
        tx_enable = 1'b0;
        tx_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("rst");

        // Single byte latency and the trig_lvl=1 threshold drain.
        for (int i = 0; i < 17; i++) begin
            wr_en     = vt[i].wr;
            wr_data   = vt[i].dat;
            tx_enable = vt[i].en;
            tx_ready  = vt[i].rdy;
            trig_lvl  = vt[i].trig;
            if (vt[i].acc) sb.push_back(vt[i].dat);
            tick();
            chk($sformatf("v%0d_ptr", i),  32'(fifo_ptr), 32'(vt[i].e_ptr));
            chk($sformatf("v%0d_emp", i),  32'(empty),    32'(vt[i].e_emp));
            chk($sformatf("v%0d_full", i), 32'(full),     32'(vt[i].e_full));
            chk($sformatf("v%0d_thr", i),  32'(thr_irq),  32'(vt[i].e_thr));
            chk($sformatf("v%0d_vld", i),  32'(tx_valid), 32'(vt[i].e_vld));
            chk($sformatf("v%0d_ovr", i),  32'(ovr_err),  32'(0));
        end
        wr_en = 1'b0;

        // Fill to full, overrun, reject writes while full (also during a pop), drain across wrap.
        trig_lvl  = 2'd2;
        tx_enable = 1'b0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            if (i < 16) sb.push_back(8'(i));
            tick();
            chk($sformatf("fill%0d_ptr", i),  32'(fifo_ptr), (i < 16) ? 32'(i + 1) : 32'(16));
            chk($sformatf("fill%0d_full", i), 32'(full),     32'(i >= 15));
            chk($sformatf("fill%0d_thr", i),  32'(thr_irq),  32'((i + 1) <= 4));
            chk($sformatf("fill%0d_ovr", i),  32'(ovr_err),  32'(i == 16));
        end
        tx_enable = 1'b1;
        wr_data   = 8'h11;
        tick();
        wr_data   = 8'h12;
        tick();
        chk("full_pop_ptr",  32'(fifo_ptr), 32'(15));
        chk("full_pop_full", 32'(full),     32'(0));
        wr_en = 1'b0;
        drain("wrap_drain");
        tick();
        tick();
        chk("wrap_ptr",        32'(fifo_ptr), 32'(0));
        chk("wrap_emp",        32'(empty),    32'(1));
        chk("ovr_sticky",      32'(ovr_err),  32'(1));

        // Stalled serializer: byte stays presented while tx_enable drops.
        tx_ready  = 1'b0;
        tx_enable = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'h5A;
        sb.push_back(8'h5A);
        tick();
        wr_data   = 8'h5B;
        sb.push_back(8'h5B);
        tick();
        wr_en = 1'b0;
        tick();
        chk("stall_vld0",  32'(tx_valid), 32'(1));
        chk("stall_data0", 32'(tx_data),  32'(8'h5A));
        tx_enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("stall%0d_vld", k),  32'(tx_valid), 32'(1));
            chk($sformatf("stall%0d_data", k), 32'(tx_data),  32'(8'h5A));
        end
        tx_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("gated%0d_vld", k), 32'(tx_valid), 32'(0));
            chk($sformatf("gated%0d_ptr", k), 32'(fifo_ptr), 32'(1));
            tick();
        end
        tx_enable = 1'b1;
        drain("stall_drain");
        tick();
        tick();

        // Flush while presenting, with a concurrent write and handshake.
        tx_enable = 1'b0;
        tx_ready  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            sb.push_back(8'(8'h60 + i));
            tick();
        end
        wr_en     = 1'b0;
        tx_enable = 1'b1;
        tick();
        tick();
        chk("preclr_vld", 32'(tx_valid), 32'(1));
        chk("preclr_ptr", 32'(fifo_ptr), 32'(5));
        chk("preclr_ovr", 32'(ovr_err),  32'(1));
        fifo_clr = 1'b1;
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        tx_ready = 1'b1;
        tick();
        sb.delete();
        fifo_clr = 1'b0;
        wr_en    = 1'b0;
        chk("clr_ptr",  32'(fifo_ptr), 32'(0));
        chk("clr_vld",  32'(tx_valid), 32'(0));
        chk("clr_emp",  32'(empty),    32'(1));
        chk("clr_ovr",  32'(ovr_err),  32'(0));
        for (int k = 0; k < 4; k++) tick();
        chk("postclr_vld", 32'(tx_valid), 32'(0));
        chk("postclr_ptr", 32'(fifo_ptr), 32'(0));

        // Asynchronous reset while presenting with the FIFO half full.
        tx_ready  = 1'b0;
        tx_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            sb.push_back(8'(8'h80 + i));
            tick();
        end
        wr_en     = 1'b0;
        tx_enable = 1'b1;
        tick();
        tick();
        chk("prerst_vld", 32'(tx_valid), 32'(1));
        chk("prerst_ptr", 32'(fifo_ptr), 32'(7));
        reset = 1'b1;
        #1;
        chk_reset_vals("arst");
        sb.delete();
        tick();
        tick();
        reset     = 1'b0;
        tx_enable = 1'b1;
        tx_ready  = 1'b1;
        wr_en     = 1'b1;
        wr_data   = 8'hC3;
        sb.push_back(8'hC3);
        tick();
        wr_en = 1'b0;
        drain("post_reset_drain");
        tick();
        tick();
        chk("final_ptr", 32'(fifo_ptr), 32'(0));
        chk("final_emp", 32'(empty),    32'(1));
        chk("final_vld", 32'(tx_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
